// File: rtl/cfu_port_router.sv
// cfu_port_router: routes core CFU requests to NUM_PORTS accelerators and
// returns responses in issue order through an order FIFO. Invalid-port
// requests and hung accelerators are answered with synthesised error
// responses so the core never deadlocks.
module cfu_port_router #(
  parameter int unsigned NUM_PORTS       = 2,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_cfu_csr,
  input  logic [8:0]                req_id,
  input  logic [7:0]                req_cfu,
  input  logic [7:0]                req_state,
  input  logic [9:0]                req_func,
  input  logic [31:0]               req_insn,
  input  logic [31:0]               req_data0,
  input  logic [31:0]               req_data1,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [8:0]                resp_id,
  output logic [2:0]                resp_status,
  output logic [31:0]               resp_data,
  output logic [NUM_PORTS-1:0]      p_req_valid,
  input  logic [NUM_PORTS-1:0]      p_req_ready,
  output logic                      p_req_cfu_csr,
  output logic [8:0]                p_req_id,
  output logic [7:0]                p_req_state,
  output logic [9:0]                p_req_func,
  output logic [31:0]               p_req_insn,
  output logic [31:0]               p_req_data0,
  output logic [31:0]               p_req_data1,
  input  logic [NUM_PORTS-1:0]      p_resp_valid,
  output logic [NUM_PORTS-1:0]      p_resp_ready,
  input  logic [9*NUM_PORTS-1:0]    p_resp_id,
  input  logic [3*NUM_PORTS-1:0]    p_resp_status,
  input  logic [32*NUM_PORTS-1:0]   p_resp_data
);
  localparam int unsigned PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam int unsigned AW = $clog2(MAX_OUTSTANDING);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);
  localparam logic [TW-1:0] T_LAST  = TW'(TIMEOUT_CYCLES - 1);

  // Request register (payload shared by all ports)
  logic [NUM_PORTS-1:0] p_req_valid_q, p_req_valid_d;
  logic        cfu_csr_q, cfu_csr_d;
  logic [8:0]  id_q, id_d;
  logic [7:0]  state_q, state_d;
  logic [9:0]  func_q, func_d;
  logic [31:0] insn_q, insn_d, data0_q, data0_d, data1_q, data1_d;

  // Order FIFO
  logic [PW-1:0] fifo_port_q [MAX_OUTSTANDING];
  logic [PW-1:0] fifo_port_d [MAX_OUTSTANDING];
  logic [8:0]    fifo_id_q   [MAX_OUTSTANDING];
  logic [8:0]    fifo_id_d   [MAX_OUTSTANDING];
  logic          fifo_err_q  [MAX_OUTSTANDING];
  logic          fifo_err_d  [MAX_OUTSTANDING];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Timeout and stale tracking
  logic [TW-1:0] timer_q, timer_d;
  logic [CW-1:0] stale_q [NUM_PORTS];
  logic [CW-1:0] stale_d [NUM_PORTS];

  // Response register
  logic        resp_valid_q, resp_valid_d;
  logic [8:0]  resp_id_q, resp_id_d;
  logic [2:0]  resp_status_q, resp_status_d;
  logic [31:0] resp_data_q, resp_data_d;

  logic          req_busy, req_drain, req_fire, req_port_ok;
  logic          fifo_ne, load_ok, can_serve;
  logic          err_pop, fwd_pop, to_pop, pop;
  logic [PW-1:0] head_port;
  logic [8:0]    head_id;
  logic          head_err;
  logic          h_valid;
  logic [8:0]    h_id;
  logic [2:0]    h_status;
  logic [31:0]   h_data;
  logic [CW-1:0] h_stale;

  assign req_busy    = |p_req_valid_q;
  assign req_drain   = |(p_req_valid_q & p_req_ready);
  assign req_ready   = ~rst & (count_q < MAX_CNT) & (~req_busy | req_drain);
  assign req_fire    = req_valid & req_ready;
  assign req_port_ok = req_cfu < 8'(NUM_PORTS);

  assign fifo_ne   = count_q != '0;
  assign head_port = fifo_port_q[rd_ptr_q];
  assign head_id   = fifo_id_q[rd_ptr_q];
  assign head_err  = fifo_err_q[rd_ptr_q];
  assign load_ok   = ~resp_valid_q | resp_ready;
  assign can_serve = fifo_ne & load_ok;

  // Select the head port's response signals
  always_comb begin
    h_valid  = 1'b0;
    h_id     = '0;
    h_status = '0;
    h_data   = '0;
    h_stale  = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      if (head_port == PW'(p)) begin
        h_valid  = p_resp_valid[p];
        h_id     = p_resp_id[p*9 +: 9];
        h_status = p_resp_status[p*3 +: 3];
        h_data   = p_resp_data[p*32 +: 32];
        h_stale  = stale_q[p];
      end
    end
  end

  // A real head response beats a timeout in the same cycle; a stale port's
  // response is always discarded rather than forwarded.
  assign err_pop = can_serve & head_err;
  assign fwd_pop = can_serve & ~head_err & h_valid & (h_stale == '0);
  assign to_pop  = can_serve & ~head_err & ~fwd_pop & (timer_q == T_LAST);
  assign pop     = err_pop | fwd_pop | to_pop;

  // Per-port response ready: drain stale responses, else accept at the head
  always_comb begin
    p_resp_ready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      p_resp_ready[p] = (stale_q[p] != '0) |
                        (can_serve & ~head_err & (head_port == PW'(p)));
    end
  end

  // Request register next state: clear on drain, load on valid-port handshake
  always_comb begin
    p_req_valid_d = p_req_valid_q;
    cfu_csr_d     = cfu_csr_q;
    id_d          = id_q;
    state_d       = state_q;
    func_d        = func_q;
    insn_d        = insn_q;
    data0_d       = data0_q;
    data1_d       = data1_q;
    if (req_drain) p_req_valid_d = '0;
    if (req_fire && req_port_ok) begin
      for (int unsigned p = 0; p < NUM_PORTS; p++) begin
        p_req_valid_d[p] = (req_cfu == 8'(p));
      end
      cfu_csr_d = req_cfu_csr;
      id_d      = req_id;
      state_d   = req_state;
      func_d    = req_func;
      insn_d    = req_insn;
      data0_d   = req_data0;
      data1_d   = req_data1;
    end
  end

  // Order FIFO, timeout counter and stale counters next state
  always_comb begin
    fifo_port_d = fifo_port_q;
    fifo_id_d   = fifo_id_q;
    fifo_err_d  = fifo_err_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (req_fire) begin
      fifo_port_d[wr_ptr_q] = req_cfu[PW-1:0];
      fifo_id_d[wr_ptr_q]   = req_id;
      fifo_err_d[wr_ptr_q]  = ~req_port_ok;
      wr_ptr_d              = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    if (req_fire && !pop)      count_d = count_q + CW'(1);
    else if (!req_fire && pop) count_d = count_q - CW'(1);

    // Saturates at the last value so a backpressured head times out as soon
    // as the response register frees up.
    if (pop || !fifo_ne)      timer_d = '0;
    else if (timer_q != T_LAST) timer_d = timer_q + TW'(1);
    else                        timer_d = timer_q;

    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      logic dec, inc;
      dec = (stale_q[p] != '0) & p_resp_valid[p];
      inc = to_pop & (head_port == PW'(p)) & ((stale_q[p] != MAX_CNT) | dec);
      stale_d[p] = stale_q[p] - CW'(dec) + CW'(inc);
    end
  end

  // Response register next state
  always_comb begin
    resp_valid_d  = resp_valid_q;
    resp_id_d     = resp_id_q;
    resp_status_d = resp_status_q;
    resp_data_d   = resp_data_q;
    if (resp_ready) resp_valid_d = 1'b0;
    if (pop) begin
      resp_valid_d = 1'b1;
      resp_id_d    = head_id;
      if (fwd_pop) begin
        resp_status_d = (h_id != head_id) ? 3'b100 : h_status;
        resp_data_d   = h_data;
      end else begin
        resp_status_d = err_pop ? 3'b010 : 3'b011;
        resp_data_d   = '0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_req_valid_q <= '0;
      cfu_csr_q     <= 1'b0;
      id_q          <= '0;
      state_q       <= '0;
      func_q        <= '0;
      insn_q        <= '0;
      data0_q       <= '0;
      data1_q       <= '0;
      for (int unsigned i = 0; i < MAX_OUTSTANDING; i++) begin
        fifo_port_q[i] <= '0;
        fifo_id_q[i]   <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      timer_q       <= '0;
      for (int unsigned p = 0; p < NUM_PORTS; p++) stale_q[p] <= '0;
      resp_valid_q  <= 1'b0;
      resp_id_q     <= '0;
      resp_status_q <= '0;
      resp_data_q   <= '0;
    end else begin
      p_req_valid_q <= p_req_valid_d;
      cfu_csr_q     <= cfu_csr_d;
      id_q          <= id_d;
      state_q       <= state_d;
      func_q        <= func_d;
      insn_q        <= insn_d;
      data0_q       <= data0_d;
      data1_q       <= data1_d;
      fifo_port_q   <= fifo_port_d;
      fifo_id_q     <= fifo_id_d;
      fifo_err_q    <= fifo_err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      timer_q       <= timer_d;
      stale_q       <= stale_d;
      resp_valid_q  <= resp_valid_d;
      resp_id_q     <= resp_id_d;
      resp_status_q <= resp_status_d;
      resp_data_q   <= resp_data_d;
    end
  end

  assign p_req_valid   = p_req_valid_q;
  assign p_req_cfu_csr = cfu_csr_q;
  assign p_req_id      = id_q;
  assign p_req_state   = state_q;
  assign p_req_func    = func_q;
  assign p_req_insn    = insn_q;
  assign p_req_data0   = data0_q;
  assign p_req_data1   = data1_q;
  assign resp_valid    = resp_valid_q;
  assign resp_id       = resp_id_q;
  assign resp_status   = resp_status_q;
  assign resp_data     = resp_data_q;

endmodule
